up_down_counter_3b: RTL and testbench

Free-running 3-bit binary counter whose direction is chosen every clock by a single control input. It counts up when `flag` is high and down when `flag` is low, wrapping modulo 8 in both directions. It is a leaf block: a general-purpose sequence/index generator with no handshake, sitting directly on the system clock and reset.

---
 rtl/up_down_counter_3b.sv | 36 +++
 tb/tb_up_down_counter_3b.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/up_down_counter_3b.sv
// up_down_counter_3b: free-running modulo-2^WIDTH counter whose direction is
// picked every clock by flag (1 = up, 0 = down). Async active-high clear.
module up_down_counter_3b #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: step by exactly one in the selected direction, natural wrap.
  always_comb begin
    count_d = count_q;
    if (flag) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // State register; reset clears immediately and holds while asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_up_down_counter_3b.sv
// Self-checking bench for up_down_counter_3b: directed vector table,
// hand-written corner sequences and randomized run against a reference model.
module tb_up_down_counter_3b;

  logic       clk;
  logic       rst;
  logic       flag;
  logic [2:0] count;

  int unsigned n_checks;
  int unsigned n_errors;

  typedef struct {
    logic       rst;
    logic       flag;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [24];

  up_down_counter_3b #(.WIDTH(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .flag (flag),
    .count(count)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [2:0] exp);
    n_checks++;
    if (count !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: count=%b expected=%b", name, $time, count, exp);
    end
  endtask

  // Drive inputs on the falling edge, check 1 ns after the next rising edge.
  task automatic step(input logic r, input logic f, input logic [2:0] exp,
                      input string name);
    @(negedge clk);
    rst  = r;
    flag = f;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // Higher-level reference: the counter value as an integer modulo 8.
  function automatic int ref_next(input int v, input logic r, input logic f);
    if (r) return 0;
    return f ? (v + 1) % 8 : (v + 7) % 8;
  endfunction

  initial begin
    int m;
    logic r;
    logic f;

    n_checks = 0;
    n_errors = 0;

    // Up 1..7, down 6..0 then wrap to 7, up-wrap to 0, full up ramp and wrap.
    vecs = '{
      '{1'b0, 1'b1, 3'd1}, '{1'b0, 1'b1, 3'd2}, '{1'b0, 1'b1, 3'd3},
      '{1'b0, 1'b1, 3'd4}, '{1'b0, 1'b1, 3'd5}, '{1'b0, 1'b1, 3'd6},
      '{1'b0, 1'b1, 3'd7},
      '{1'b0, 1'b0, 3'd6}, '{1'b0, 1'b0, 3'd5}, '{1'b0, 1'b0, 3'd4},
      '{1'b0, 1'b0, 3'd3}, '{1'b0, 1'b0, 3'd2}, '{1'b0, 1'b0, 3'd1},
      '{1'b0, 1'b0, 3'd0}, '{1'b0, 1'b0, 3'd7},
      '{1'b0, 1'b1, 3'd0},
      '{1'b0, 1'b1, 3'd1}, '{1'b0, 1'b1, 3'd2}, '{1'b0, 1'b1, 3'd3},
      '{1'b0, 1'b1, 3'd4}, '{1'b0, 1'b1, 3'd5}, '{1'b0, 1'b1, 3'd6},
      '{1'b0, 1'b1, 3'd7}, '{1'b0, 1'b1, 3'd0}
    };

    // Reset with flag undriven: count must be 0, never X.
    rst  = 1'b1;
    flag = 1'bx;
    #1;
    check("reset_async", 3'd0);
    @(posedge clk); #1;
    check("reset_edge5", 3'd0);
    @(posedge clk); #1;
    check("reset_edge15", 3'd0);

    // Directed table; first entry releases reset at 20 ns.
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].rst, vecs[i].flag, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Direction switch mid-ramp: 1,2,3 up, 2,1 down, 2,3 up.
    step(1'b0, 1'b1, 3'd1, "sw_up1");
    step(1'b0, 1'b1, 3'd2, "sw_up2");
    step(1'b0, 1'b1, 3'd3, "sw_up3");
    step(1'b0, 1'b0, 3'd2, "sw_dn2");
    step(1'b0, 1'b0, 3'd1, "sw_dn1");
    step(1'b0, 1'b1, 3'd2, "sw_up2b");
    step(1'b0, 1'b1, 3'd3, "sw_up3b");
    step(1'b0, 1'b1, 3'd4, "sw_up4");
    step(1'b0, 1'b1, 3'd5, "pre_rst5");

    // Async reset between edges from count=5, hold, release with flag=0.
    #2;
    rst  = 1'b1;
    flag = 1'b1;
    #1;
    check("mid_rst_async", 3'd0);
    @(posedge clk); #1;
    check("mid_rst_hold1", 3'd0);
    @(posedge clk); #1;
    check("mid_rst_hold2", 3'd0);
    step(1'b0, 1'b0, 3'd7, "rel_down7");
    m = 7;

    // Alternating ramps: 7 edges per direction, starting downward from 7.
    for (int blk = 0; blk < 6; blk++) begin
      for (int e = 0; e < 7; e++) begin
        f = (blk % 2) != 0;
        m = ref_next(m, 1'b0, f);
        step(1'b0, f, 3'(m), $sformatf("alt%0d_%0d", blk, e));
      end
    end

    // Randomized direction with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(15) == 0);
      f = 1'($urandom_range(1));
      m = ref_next(m, r, f);
      step(r, f, 3'(m), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
